// File: rtl/and2_pipelined.sv
// Two-stage registered, vectorised 2-input AND.
// Stage 1 captures the operands; stage 2 captures their bitwise AND and drives c.
// Every output bit is one flop, and no combinational path runs from a or b to c.
module and2_pipelined #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;

  // Next-state logic.
  // Reset clears both stages together, so all in-flight data is dropped in a single edge.
  always_comb begin
    a_d = a;
    b_d = b;
    c_d = a_q & b_q;
    if (reset) begin
      a_d = '0;
      b_d = '0;
      c_d = '0;
    end
  end

  // Pipeline registers.
  // Reset is synchronous, and it is applied through the next-state values above.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
  end

  assign c = c_q;

endmodule

// File: tb/tb_and2_pipelined.sv
// Directed bench for and2_pipelined (WIDTH = 2).
// Inputs change 1 ns after each rising edge, and c is sampled at that same point.
// Each expected value below is c after the edge: the AND of the operands driven one step earlier.
module tb_and2_pipelined;

  logic       clk;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] c;

  int n_cmp;
  int n_bad;

  and2_pipelined #(
    .WIDTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .c    (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] exp);
    n_cmp++;
    assert (c === exp)
    else begin
      n_bad++;
      $error("FAIL %s: c=%b expected %b", tag, c, exp);
    end
  endtask

  // Apply operands and reset, advance one edge, then check c.
  task automatic step(input string tag, input logic [1:0] av, input logic [1:0] bv,
                      input logic rst, input logic [1:0] exp);
    a     = av;
    b     = bv;
    reset = rst;
    tick();
    chk(tag, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a     = 2'b11;
    b     = 2'b11;

    // Reset hold with operands at all ones.
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("reset_hold", 2'b00);
    end

    // Reset release: stage 2 first takes the cleared stage 1 value.
    step("release_e1", 2'b11, 2'b11, 1'b0, 2'b00);
    step("release_e2", 2'b11, 2'b11, 1'b0, 2'b11);

    // Truth table per bit.
    step("tt_00_00", 2'b00, 2'b00, 1'b0, 2'b11);
    step("tt_11_00", 2'b11, 2'b00, 1'b0, 2'b00);
    step("tt_11_11", 2'b11, 2'b11, 1'b0, 2'b00);
    step("tt_00_11", 2'b00, 2'b11, 1'b0, 2'b11);

    // Bit independence.
    step("bit_10_11", 2'b10, 2'b11, 1'b0, 2'b00);
    step("bit_01_11", 2'b01, 2'b11, 1'b0, 2'b10);
    step("bit_res01", 2'b11, 2'b11, 1'b0, 2'b01);

    // Mid-stream reset pulse.
    step("ms_11_00", 2'b11, 2'b00, 1'b0, 2'b11);
    step("ms_11_11", 2'b11, 2'b11, 1'b0, 2'b00);
    step("ms_reset", 2'b11, 2'b00, 1'b1, 2'b00);
    step("ms_post1", 2'b11, 2'b11, 1'b0, 2'b00);
    step("ms_post2", 2'b11, 2'b00, 1'b0, 2'b11);
    step("ms_post3", 2'b11, 2'b11, 1'b0, 2'b00);
    step("ms_post4", 2'b11, 2'b00, 1'b0, 2'b11);

    // Back-to-back toggling.
    step("tog0", 2'b01, 2'b10, 1'b0, 2'b00);
    step("tog1", 2'b10, 2'b01, 1'b0, 2'b00);
    step("tog2", 2'b11, 2'b10, 1'b0, 2'b00);
    step("tog3", 2'b00, 2'b01, 1'b0, 2'b10);
    step("tog4", 2'b11, 2'b11, 1'b0, 2'b00);
    step("tog5", 2'b10, 2'b10, 1'b0, 2'b11);
    step("tog6", 2'b01, 2'b11, 1'b0, 2'b10);
    step("tog7", 2'b00, 2'b00, 1'b0, 2'b01);
    step("tog_flush", 2'b00, 2'b00, 1'b0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
